mult_seq: RTL



---
 rtl/mips_pkg.sv | 14 +
 rtl/mult_step.sv | 23 ++
 rtl/mult_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core multiply path.
// Build option: MULT_SIGNED_EN enables signed mult.
package mips_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_step.sv
// One shift-add multiply step: conditional add into the
// upper half, then shift {acc, mplier} right by one.
module mult_step
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] mplier_o
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  assign addend   = mplier_i[0] ? {1'b0, mcand_i} : '0;
  assign sum      = acc_i + addend;
  assign acc_o    = {1'b0, sum[WIDTH:1]};
  assign mplier_o = {sum[0], mplier_i[WIDTH-1:1]};

endmodule

// File: rtl/mult_seq.sv
// Iterative multiply sequencer owning HI/LO.
// Build option: MULT_SIGNED_EN honours signedE.
module mult_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             multstartE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hiweW,
  input  logic             loweW,
  input  logic [WIDTH-1:0] wdataW,
  output logic             busy,
  output logic             pve,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mult_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]     acc_n;
  logic [WIDTH-1:0]   mplier_n;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_n),
    .mplier_o (mplier_n)
  );

  assign prod_raw = {acc_n[WIDTH-1:0], mplier_n};

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic ld_neg;

  assign mag_a  = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign mag_b  = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;
  assign ld_neg = signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
  assign prod   = neg_q ? -prod_raw : prod_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) neg_q <= 1'b0;
    else          neg_q <= neg_d;
  end

  always_comb begin
    neg_d = neg_q;
    if (state_q != RUN && multstartE) neg_d = ld_neg;
  end
`else
  logic unused_signed;

  assign unused_signed = signedE;
  assign mag_a         = srcaE;
  assign mag_b         = srcbE;
  assign prod          = prod_raw;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      RUN: begin
        acc_d    = acc_n;
        mplier_d = mplier_n;
        cnt_d    = cnt_q + CW'(1);
        // final step writes the product; mthi/mtlo lose here
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d      = DONE;
          {hi_d, lo_d} = prod;
        end
      end
      IDLE, DONE: begin
        if (hiweW) hi_d = wdataW;
        if (loweW) lo_d = wdataW;
        state_d = IDLE;
        if (multstartE) begin
          state_d  = RUN;
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = mag_a;
          mplier_d = mag_b;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign pve  = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
